// File: rtl/led_frame_if.sv
// led_frame_if: bundles the host write/commit controls, the led_string
// handshake and the frame buffer driven to led_string.
//   master : host side; drives wr_en/wr_addr/wr_data/commit and frame_done,
//            observes frame_start/color_string/busy/pending.
//   slave  : led_frame_ctrl side (directions reversed).
// Parameter NUM_LEDS sets the color_string width (24 bits per LED).
interface led_frame_if #(
    parameter int unsigned NUM_LEDS = 144
);
    logic                    wr_en;
    logic [7:0]              wr_addr;
    logic [23:0]             wr_data;
    logic                    commit;
    logic                    frame_done;
    logic                    frame_start;
    logic [24*NUM_LEDS-1:0]  color_string;
    logic                    busy;
    logic                    pending;

    modport master (
        output wr_en, wr_addr, wr_data, commit, frame_done,
        input  frame_start, color_string, busy, pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, frame_done,
        output frame_start, color_string, busy, pending
    );
endinterface

// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: double-buffered frame controller for a WS2812 string.
// Host writes land in a work buffer at any time; a commit schedules a frame.
// The work buffer is copied into the shadow buffer (color_string) as the FSM
// enters LOAD, frame_start pulses for that one LOAD cycle, the FSM waits in
// SEND for frame_done, then holds LATCH for LATCH_CYCLES before going idle.
// LED i lives in slice [24*(NUM_LEDS-i)-1 -: 24] (LED 0 in the MSBs).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (shared with led_string)
//   bus  : led_frame_if.slave (wr_en, wr_addr, wr_data, commit, frame_done,
//          frame_start, color_string, busy, pending)
//
// Build option: define LED_AUTO_REFRESH_EN to add a free-running counter that
// raises pending every REFRESH_CYCLES cycles; without it frames start only
// from commit and the counter does not exist.
module led_frame_ctrl #(
    parameter int unsigned NUM_LEDS       = 144,
    parameter int unsigned LATCH_CYCLES   = 6000,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input logic         clk,
    input logic         rst,
    led_frame_if.slave  bus
);
    localparam int unsigned FW  = 24 * NUM_LEDS;
    localparam int unsigned LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_CYCLES - 1);

    // Reject configurations the counters and 8-bit address cannot support.
    if (NUM_LEDS == 0 || NUM_LEDS > 256 || LATCH_CYCLES == 0 || REFRESH_CYCLES == 0) begin : g_bad_cfg
        $error("led_frame_ctrl: unsupported parameter values");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   work_q, work_d;
    logic [FW-1:0]   color_q, color_d;
    logic            pending_q, pending_d;
    logic [LCW-1:0]  latch_cnt_q, latch_cnt_d;
    logic            load_en;
    logic            refresh_tick;

`ifdef LED_AUTO_REFRESH_EN
    localparam int unsigned RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_CYCLES - 1);

    logic [RCW-1:0] refresh_cnt_q, refresh_cnt_d;

    always_comb begin
        refresh_tick  = (refresh_cnt_q == REFRESH_LAST);
        refresh_cnt_d = refresh_tick ? '0 : refresh_cnt_q + RCW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) refresh_cnt_q <= '0;
        else     refresh_cnt_q <= refresh_cnt_d;
    end
`else
    assign refresh_tick = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pending_q) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (bus.frame_done) state_d = LATCH;
            LATCH:   if (latch_cnt_q == LATCH_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.frame_start  = (state_q == LOAD);
        bus.busy         = (state_q != IDLE);
        bus.pending      = pending_q;
        bus.color_string = color_q;
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        // The copy and pending clear happen on the edge into LOAD so that
        // color_string already holds the new frame while frame_start is high.
        load_en = (state_q == IDLE) && pending_q;

        work_d = work_q;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (bus.wr_en && (32'(bus.wr_addr) == i)) begin
                work_d[24*(NUM_LEDS-i)-1 -: 24] = bus.wr_data;
            end
        end

        color_d = load_en ? work_q : color_q;

        // A new request wins over the clear so a commit on the clearing edge
        // is kept for the next frame.
        pending_d = pending_q;
        if (load_en) pending_d = 1'b0;
        if (bus.commit || refresh_tick) pending_d = 1'b1;

        latch_cnt_d = '0;
        if ((state_q == LATCH) && (latch_cnt_q != LATCH_LAST)) begin
            latch_cnt_d = latch_cnt_q + LCW'(1);
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q      <= '0;
            color_q     <= '0;
            pending_q   <= 1'b0;
            latch_cnt_q <= '0;
        end else begin
            work_q      <= work_d;
            color_q     <= color_d;
            pending_q   <= pending_d;
            latch_cnt_q <= latch_cnt_d;
        end
    end
endmodule

// File: tb/tb_led_frame_ctrl.sv
// tb_led_frame_ctrl: self-checking bench for led_frame_ctrl (default build,
// LED_AUTO_REFRESH_EN undefined). A bench-side LED model builds expected
// frames, pushed to a scoreboard queue when a commit is driven and compared
// against color_string whenever frame_start is seen.
module tb_led_frame_ctrl;
    localparam int unsigned N     = 144;
    localparam int unsigned LATCH = 6000;
    localparam int unsigned FW    = 24 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_frame_if #(.NUM_LEDS(N)) bus ();

    led_frame_ctrl #(
        .NUM_LEDS      (N),
        .LATCH_CYCLES  (LATCH),
        .REFRESH_CYCLES(50000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int passes   = 0;
    int fs_count = 0;

    logic [23:0]   model [N];
    logic [FW-1:0] sb_q [$];

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        int unsigned chk_led;
        logic [23:0] exp_val;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[24*(N-i)-1 -: 24] = model[i];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_frame(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[24*(N-i)-1 -: 24] !== exp[24*(N-i)-1 -: 24]) bad = i;
        end
        if (bad < 0) passes++;
        else $display("FAIL %s: LED%0d got %06h expected %06h", nm, bad,
                      act[24*(N-bad)-1 -: 24], exp[24*(N-bad)-1 -: 24]);
    endtask

    // Scoreboard consumer: every frame_start must match the oldest expected frame.
    initial begin
        logic fs_prev;
        fs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin
                fs_count++;
                chk("frame_start_one_cycle", {31'd0, fs_prev}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame_start: got frame_start=1 expected none");
                end else begin
                    chk_frame("frame_content", bus.color_string, sb_q.pop_front());
                end
            end
            fs_prev = bus.frame_start;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs (sampled on the next edge), then idle them.
    task automatic drive(input logic we, input logic [7:0] a, input logic [23:0] d, input logic cm);
        bus.wr_en   = we;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.commit  = cm;
        step();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;
    endtask

    // Counts further cycles until frame_start is visible. After drive() the
    // commit edge has already passed, so 1 here means 2 cycles from commit.
    task automatic wait_fs(input string nm, input int exp_steps);
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(nm, n, exp_steps);
    endtask

    // From LOAD: stay in SEND, pulse frame_done, then measure LATCH length.
    task automatic finish_frame(input int send_cycles, input bit done_in_latch);
        int cnt;
        repeat (send_cycles) step();
        chk("busy_in_send", {31'd0, bus.busy}, 32'd1);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < LATCH + 100) begin
            bus.frame_done = (done_in_latch && cnt == 100);
            step();
            cnt++;
        end
        bus.frame_done = 1'b0;
        chk("latch_cycles", cnt, LATCH);
    endtask

    initial begin
        int saved;
        logic [23:0] old5;

        vecs[0] = '{addr: 8'd200, data: 24'hFFFFFF, chk_led: 0,   exp_val: 24'h000000};
        vecs[1] = '{addr: 8'd0,   data: 24'h00CEFF, chk_led: 0,   exp_val: 24'h00CEFF};
        vecs[2] = '{addr: 8'd143, data: 24'h123456, chk_led: 143, exp_val: 24'h123456};
        vecs[3] = '{addr: 8'd144, data: 24'hABCDEF, chk_led: 143, exp_val: 24'h123456};
        vecs[4] = '{addr: 8'd77,  data: 24'h5A5A5A, chk_led: 77,  exp_val: 24'h5A5A5A};

        for (int i = 0; i < N; i++) model[i] = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.commit = 1'b0; bus.frame_done = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pending", {31'd0, bus.pending}, 32'd0);
        chk("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
        chk("rst_color_zero", {31'd0, bus.color_string == '0}, 32'd1);
        rst = 1'b0;
        step();

        // frame_done while idle has no effect.
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        chk("idle_done_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("idle_done_busy_later", {31'd0, bus.busy}, 32'd0);

        // Table: write and commit in the same cycle, one frame per record.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].addr < N) model[vecs[v].addr] = vecs[v].data;
            sb_q.push_back(model_frame());
            drive(1'b1, vecs[v].addr, vecs[v].data, 1'b1);
            chk("pending_after_commit", {31'd0, bus.pending}, 32'd1);
            wait_fs("commit_latency", 1);
            chk("led_slot", bus.color_string[24*(N-vecs[v].chk_led)-1 -: 24], vecs[v].exp_val);
            chk("pending_clear_in_load", {31'd0, bus.pending}, 32'd0);
            finish_frame(4, 1'b0);
        end

        // Writes and commits during SEND do not touch the frame in flight;
        // absorbed commits give exactly one follow-up frame.
        sb_q.push_back(model_frame());
        drive(1'b0, '0, '0, 1'b1);
        wait_fs("commit_latency_b", 1);
        old5 = model[5];
        step();
        model[5] = 24'hFFFFFF;
        drive(1'b1, 8'd5, 24'hFFFFFF, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        chk("pending_in_send", {31'd0, bus.pending}, 32'd1);
        chk("led5_in_flight", bus.color_string[24*(N-5)-1 -: 24], old5);
        sb_q.push_back(model_frame());
        finish_frame(2, 1'b0);
        saved = fs_count;
        wait_fs("followup_after_latch", 1);
        chk("led5_followup", bus.color_string[24*(N-5)-1 -: 24], 32'hFFFFFF);
        finish_frame(3, 1'b0);
        repeat (20) step();
        chk("single_followup", fs_count, saved + 1);

        // Commit in the LOAD cycle re-arms pending; reset in SEND aborts all.
        sb_q.push_back(model_frame());
        drive(1'b0, '0, '0, 1'b1);
        wait_fs("commit_latency_c", 1);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        chk("pending_rearm_in_load", {31'd0, bus.pending}, 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_pending", {31'd0, bus.pending}, 32'd0);
        chk("abort_color_zero", {31'd0, bus.color_string == '0}, 32'd1);
        for (int i = 0; i < N; i++) model[i] = '0;
        saved = fs_count;
        repeat (50) step();
        chk("no_frame_after_abort", fs_count, saved);

        // Fresh commit after reset shows a cleared work buffer; frame_done
        // inside LATCH must not shorten it.
        sb_q.push_back(model_frame());
        drive(1'b0, '0, '0, 1'b1);
        wait_fs("commit_latency_d", 1);
        finish_frame(3, 1'b1);
        repeat (10) step();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
